// File: rtl/ln_requant_sink.sv
// ln_requant_sink: requantises a signed layer-norm output stream to D_W-bit
// elements (multiply, arithmetic right shift, saturate), packs PACK elements
// per word and queues the words in a first-word-fall-through FIFO.
// Optional build macro LN_REQUANT_SINK_ROUND_EN: round half up before the
// shift instead of flooring.
module ln_requant_sink #(
  parameter int D_W        = 8,
  parameter int D_W_ACC    = 32,
  parameter int N          = 768,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic signed [D_W_ACC-1:0]   qin,
  input  logic signed [15:0]          mult,
  input  logic        [4:0]           shift,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [PACK*D_W-1:0]  out_data,
  output logic                        out_last,
  output logic                        overflow
);

  localparam int PW = D_W_ACC + 16;
  localparam int WW = PACK * D_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((64'sd1 <<< (D_W - 1)) - 64'sd1);
  localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

  logic                 v1, v2;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   s2, rnd, shifted;
  logic [D_W-1:0]       sat;
  logic [D_W-1:0]       lanes [PACK];
  logic [LW-1:0]        lane_cnt;
  logic [CW-1:0]        elem_cnt;
  logic                 done, done_last;
  logic [WW-1:0]        word;
  logic                 push_v, push_last;
  logic [WW-1:0]        push_data;
  logic [WW:0]          mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, pop, push_ok;

  // Stage 1: full-precision product
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      prod <= '0;
    end else if (enable) begin
      v1 <= in_valid;
      if (in_valid) prod <= PW'(qin) * PW'(mult);
    end
  end

  // Rounding offset and arithmetic shift of the stage-1 product
  always_comb begin
    rnd = '0;
`ifdef LN_REQUANT_SINK_ROUND_EN
    if (shift != 5'd0) rnd = (PW+1)'(1) <<< (shift - 5'd1);
`endif
    shifted = ((PW+1)'(prod) + rnd) >>> shift;
  end

  // Stage 2: shifted value
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (enable) begin
      v2 <= v1;
      if (v1) s2 <= shifted;
    end
  end

  // Saturate to the signed D_W range
  always_comb begin
    sat = s2[D_W-1:0];
    if (s2 > SAT_MAX) sat = SAT_MAX[D_W-1:0];
    else if (s2 < SAT_MIN) sat = SAT_MIN[D_W-1:0];
  end

  // Stage 3: lane write and element/lane counters; done pulses when a word completes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < PACK; k++) lanes[k] <= '0;
      lane_cnt  <= '0;
      elem_cnt  <= '0;
      done      <= 1'b0;
      done_last <= 1'b0;
    end else begin
      done <= 1'b0;
      if (enable && v2) begin
        lanes[lane_cnt] <= sat;
        elem_cnt <= (elem_cnt == CW'(N - 1)) ? '0 : elem_cnt + CW'(1);
        if (lane_cnt == LW'(PACK - 1)) begin
          lane_cnt  <= '0;
          done      <= 1'b1;
          done_last <= (elem_cnt == CW'(N - 1));
        end else begin
          lane_cnt <= lane_cnt + LW'(1);
        end
      end
    end
  end

  // Flatten lanes into the packed word
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < PACK; k++) word[k*D_W +: D_W] = lanes[k];
  end

  // Push stage: snapshot the completed word before lane 0 of the next word lands.
  // Not gated by enable so a completed word is always pushed exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_v    <= 1'b0;
      push_data <= '0;
      push_last <= 1'b0;
    end else begin
      push_v <= done;
      if (done) begin
        push_data <= word;
        push_last <= done_last;
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && out_ready;
  assign push_ok = push_v && (!full || pop);

  // FIFO storage (data path only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= {push_last, push_data};
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_v && full && !pop) overflow <= 1'b1;
    end
  end

  // First-word-fall-through head; zero when empty
  always_comb begin
    out_valid = !empty;
    {out_last, out_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_ln_requant_sink.sv
// Scoreboard bench for ln_requant_sink (N=8, PACK=4, D_W=8, FIFO_DEPTH=16).
module tb_ln_requant_sink;

  logic               clk = 1'b0;
  logic               rst, enable, in_valid, out_ready;
  logic signed [31:0] qin;
  logic signed [15:0] mult;
  logic        [4:0]  shift;
  logic               out_valid, out_last, overflow;
  logic        [31:0] out_data;

  typedef struct packed { logic [31:0] data; logic last; } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat_cyc = -1;
  bit lat_arm = 1'b0;
  bit hold_pend = 1'b0;
  logic [31:0] held_d;
  logic        held_l;

  ln_requant_sink #(.D_W(8), .D_W_ACC(32), .N(8), .PACK(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .qin(qin),
    .mult(mult), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on each accepted word, checks head stability under stall
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("stall_stable", {31'd0, out_last, out_data}, {31'd0, held_l, held_d});
      hold_pend = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (lat_arm && out_valid) begin
        lat_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", {31'd0, out_last, out_data}, 64'hDEAD_0000_0000);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("word", {31'd0, out_last, out_data}, {31'd0, e.last, e.data});
        end
      end
    end
  end

  task automatic send(input int v);
    in_valid = 1'b1;
    qin = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int e3_cyc, e0_cyc;
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    qin = 0; mult = 16'sd1; shift = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic packing and first-word latency
    expect_word(32'h03020100, 1'b0);
    expect_word(32'h07060504, 1'b1);
    lat_arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(i);
      if (i == 3) e3_cyc = cyc;
    end
    drain();
    check("latency", 64'(lat_cyc - e3_cyc), 64'd4);

    // Saturation
    expect_word(32'h0100807F, 1'b0);
    expect_word(32'h7F80FF02, 1'b1);
    send(300); send(-300); send(0); send(1);
    send(2); send(-1); send(-128); send(127);
    drain();

    // Shift with/without rounding
    mult = 16'sd3; shift = 5'd2;
`ifdef LN_REQUANT_SINK_ROUND_EN
    expect_word(32'h0003FC04, 1'b0);
    expect_word(32'hFF0201FF, 1'b1);
`else
    expect_word(32'h0003FC03, 1'b0);
    expect_word(32'hFE0100FF, 1'b1);
`endif
    send(5); send(-5); send(4); send(0);
    send(-1); send(1); send(2); send(-2);
    drain();
    mult = 16'sd1; shift = 5'd0;
    repeat (4) @(posedge clk);
    #1;

    // Enable low for 3 cycles mid-word with in_valid held
    expect_word(32'h17161514, 1'b0);
    expect_word(32'h1B1A1918, 1'b1);
    lat_arm = 1'b1;
    send(20);
    e0_cyc = cyc;
    send(21);
    in_valid = 1'b1; qin = 22; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 22; i < 28; i++) send(i);
    drain();
    check("enable_stall_delay", 64'(lat_cyc - e0_cyc), 64'd10);

    // Overflow: 17 words into a 16-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int w = 0; w < 16; w++)
      expect_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, (w % 2) == 1);
    for (int i = 0; i < 68; i++) send(i);
    repeat (8) @(posedge clk);
    #1;
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_head_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("ovf_no_17th", 64'(out_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset clears overflow; reset mid-row discards the partial row
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_clears_ovf", 64'(overflow), 64'd0);
    for (int i = 50; i < 56; i++) send(i);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_word(32'h03020100, 1'b0);
    expect_word(32'h07060504, 1'b1);
    for (int i = 0; i < 8; i++) send(i);
    drain();
    check("midrow_rst_ovf", 64'(overflow), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ln_requant_sink.md
LN_REQUANT_SINK -- requirements
Module: ln_requant_sink

Interface
REQ-001 Parameter D_W, default 8: signed output element width.
REQ-002 Parameter D_W_ACC, default 32: signed input element width, matching the layer-norm output stream.
REQ-003 Parameter N, default 768: elements per row; SHALL be a multiple of PACK.
REQ-004 Parameter PACK, default 4: elements per output word.
REQ-005 Parameter FIFO_DEPTH, default 16: output FIFO depth in words; SHALL be a power of 2.
REQ-006 clk  input  1: single clock; all logic is on the rising edge.
REQ-007 rst  input  1: synchronous, active-high reset.
REQ-008 enable  input  1: when low, the input pipeline and element counter hold.
REQ-009 in_valid  input  1: qin is valid this cycle; there is no backpressure.
REQ-010 qin  input  D_W_ACC: signed layer-norm output element.
REQ-011 mult  input  16: signed requant multiplier, static for the duration of a row.
REQ-012 shift  input  5: requant right-shift amount, 0..31, static for the duration of a row.
REQ-013 out_valid  output  1: the FIFO head word is valid.
REQ-014 out_ready  input  1: the downstream consumer accepts the head word.
REQ-015 out_data  output  PACK*D_W: packed word; element k occupies bits [k*D_W +: D_W].
REQ-016 out_last  output  1: the head word holds element N-1 of a row.
REQ-017 overflow  output  1: sticky flag, set when a word is dropped because the FIFO is full.

Function
REQ-018 Stage 1 SHALL register prod = qin*mult as a signed D_W_ACC+16-bit value.
REQ-019 Stage 2 SHALL register prod >>> shift (arithmetic shift), with rounding per REQ-033.
REQ-020 Stage 3 SHALL saturate the stage-2 result to [-2^(D_W-1), 2^(D_W-1)-1] and write it into lane (elem_cnt mod PACK) of the pack register.
REQ-021 elem_cnt SHALL increment on each accepted element and wrap from N-1 to 0.
REQ-022 When lane PACK-1 is written, the completed word and its last flag (elem_cnt == N-1) SHALL be pushed to the FIFO on the next cycle.
REQ-023 Latency: when the final element of a word is sampled at cycle t, out_valid SHALL be high at t+4 if the FIFO was empty.
REQ-024 While enable is low, all stage registers, valid bits, and elem_cnt SHALL hold; the FIFO push/pop logic remains active.
REQ-025 The FIFO SHALL be first-word-fall-through; a pop occurs when out_valid && out_ready.
REQ-026 A push while the FIFO is full and no pop occurs that cycle SHALL drop the word and set overflow.
REQ-027 A simultaneous push and pop while the FIFO is full SHALL accept both; overflow is not set.
REQ-028 A pop while the FIFO is empty SHALL have no effect; out_valid stays 0.
REQ-029 out_data and out_last SHALL be stable while out_valid && !out_ready.
REQ-030 Consecutive rows SHALL stream back-to-back with no idle cycles required.

Reset
REQ-031 On rst: out_valid=0, out_data=0, out_last=0, overflow=0, elem_cnt=0, all pipeline valid bits=0, and the FIFO is empty.
REQ-032 A reset mid-row SHALL discard any partial word and in-flight elements; the next accepted element is element 0.

Configuration
REQ-033 Macro LN_REQUANT_SINK_ROUND_EN.
- Defined: stage 2 adds 1<<(shift-1) before shifting when shift>0 (round half up).
- Undefined: plain arithmetic shift (floor).
- shift=0 is identical in both builds.

Verification
REQ-034 N=8, PACK=4, mult=1, shift=0, qin=0..7 in consecutive cycles, out_ready=1 -> words 0x03020100 then 0x07060504; out_last=1 on the second word only; first out_valid 4 cycles after element 3.
REQ-035 mult=1, shift=0, qin=300 then -300 -> lanes 0x7F and 0x80 (saturated).
REQ-036 mult=3, shift=2, qin=5 -> lane 4 with LN_REQUANT_SINK_ROUND_EN defined, 3 without; qin=-5 -> -4 with the macro, -4 without.
REQ-037 FIFO_DEPTH=16, out_ready=0, 17 words streamed -> 16 words retained, overflow=1; then out_ready=1 -> exactly the first 16 words drain in order, and overflow stays 1.
REQ-038 rst asserted after element 5 of a row, then a fresh row 0..N-1 -> no partial word emitted; the first word holds elements 0..3 of the new row; overflow=0.
REQ-039 enable toggled low for 3 cycles mid-word with in_valid held -> output words are identical to the uninterrupted run, delayed by 3 cycles.
